// File: rtl/bcd_sched_pkg.sv
// Shared state encoding and default sizing for the BCD conversion scheduler.
package bcd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_e;

  localparam int DEF_INPUT_WIDTH    = 16;
  localparam int DEF_DECIMAL_DIGITS = 5;
  localparam int DEF_NUM_REQ        = 4;

endpackage

// File: rtl/bcd_shift_engine.sv
// Double-dabble engine: one add-3/shift step per cycle, MSB of the binary value first.
module bcd_shift_engine import bcd_sched_pkg::*; #(
  parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
  parameter int DECIMAL_DIGITS = DEF_DECIMAL_DIGITS
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [INPUT_WIDTH-1:0]        value_i,
  output logic                          done_o,
  output logic [DECIMAL_DIGITS*4-1:0]   bcd_o
);

  localparam int CW = $clog2(INPUT_WIDTH + 1);
  localparam int AW = DECIMAL_DIGITS * 4;

  logic [AW-1:0]          acc_q, acc_d, acc_adj;
  logic [INPUT_WIDTH-1:0] shift_q;
  logic [CW-1:0]          cnt_q;

  // Carries out of the top digit are dropped, so a narrow accumulator yields value mod 10^DIGITS.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (acc_q[4*d +: 4] > 4'd4) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
    acc_d = {acc_adj[AW-2:0], shift_q[INPUT_WIDTH-1]};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      acc_q   <= '0;
      shift_q <= value_i;
      cnt_q   <= CW'(INPUT_WIDTH);
    end else if (cnt_q != '0) begin
      acc_q   <= acc_d;
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  // High during the cycle whose closing edge performs the final shift.
  assign done_o = (cnt_q == CW'(1));
  assign bcd_o  = acc_q;

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin arbiter and control FSM sharing one serial binary-to-BCD engine among requesters.
module bcd_convert_scheduler import bcd_sched_pkg::*; #(
  parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
  parameter int DECIMAL_DIGITS = DEF_DECIMAL_DIGITS,
  parameter int NUM_REQ        = DEF_NUM_REQ
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]    req_data_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  output logic [DECIMAL_DIGITS*4-1:0]       bcd_out,
  output logic [$clog2(NUM_REQ)-1:0]        bcd_id_out,
  output logic                              bcd_valid_out,
  output logic                              busy_out
);

  localparam int IDW = $clog2(NUM_REQ);

  state_e                      state_q;
  logic [IDW-1:0]              last_grant_q, cur_id_q, bcd_id_q, grant_idx;
  logic [DECIMAL_DIGITS*4-1:0] bcd_q, eng_bcd;
  logic                        bcd_valid_q, busy_q;
  logic                        grant_found, start, eng_done;
  logic [INPUT_WIDTH-1:0]      sel_data;

  // Cyclic search starting just after the previous winner.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!grant_found && req_valid_in[(int'(last_grant_q) + i) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(last_grant_q) + i) % NUM_REQ);
      end
    end
  end

  assign start         = (state_q == IDLE) && grant_found;
  assign req_ready_out = start ? (NUM_REQ'(1) << grant_idx) : '0;
  assign sel_data      = req_data_in[int'(grant_idx)*INPUT_WIDTH +: INPUT_WIDTH];

  bcd_shift_engine #(
    .INPUT_WIDTH    (INPUT_WIDTH),
    .DECIMAL_DIGITS (DECIMAL_DIGITS)
  ) u_engine (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .start_i (start),
    .value_i (sel_data),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      cur_id_q     <= '0;
      bcd_id_q     <= '0;
      bcd_q        <= '0;
      bcd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            busy_q       <= 1'b1;
            state_q      <= CONVERT;
          end
        end
        CONVERT: begin
          if (eng_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q       <= eng_bcd;
          bcd_id_q    <= cur_id_q;
          bcd_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bcd_out       = bcd_q;
  assign bcd_id_out    = bcd_id_q;
  assign bcd_valid_out = bcd_valid_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed bench: grant order, conversion results, pulse timing, reset abort, truncated digits.
module tb_bcd_convert_scheduler;

  logic        clk;
  logic        rstN;
  logic [3:0]  reqValid;
  logic [63:0] reqData;
  logic [3:0]  reqReady;
  logic [19:0] bcdOut;
  logic [1:0]  bcdId;
  logic        bcdValid;
  logic        busy;

  logic [3:0]  reqValid2;
  logic [63:0] reqData2;
  logic [3:0]  reqReady2;
  logic [15:0] bcdOut2;
  logic [1:0]  bcdId2;
  logic        bcdValid2;
  logic        busy2;

  int checkCount = 0;
  int failCount  = 0;

  bcd_convert_scheduler dut (
    .clk_in        (clk),
    .rst_n_in      (rstN),
    .req_valid_in  (reqValid),
    .req_data_in   (reqData),
    .req_ready_out (reqReady),
    .bcd_out       (bcdOut),
    .bcd_id_out    (bcdId),
    .bcd_valid_out (bcdValid),
    .busy_out      (busy)
  );

  bcd_convert_scheduler #(
    .INPUT_WIDTH    (16),
    .DECIMAL_DIGITS (4),
    .NUM_REQ        (4)
  ) dut4 (
    .clk_in        (clk),
    .rst_n_in      (rstN),
    .req_valid_in  (reqValid2),
    .req_data_in   (reqData2),
    .req_ready_out (reqReady2),
    .bcd_out       (bcdOut2),
    .bcd_id_out    (bcdId2),
    .bcd_valid_out (bcdValid2),
    .busy_out      (busy2)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request from a single requester and wait for its result pulse.
  task automatic applyStimulus(input int k, input logic [15:0] v, output int pulseCycle,
                               output logic [19:0] res, output logic [1:0] id);
    reqValid = 4'b0;
    reqValid[k] = 1'b1;
    reqData[k*16 +: 16] = v;
    @(negedge clk);
    checkOutput("grant", 32'(reqReady), 32'(4'b1 << k));
    @(posedge clk);
    #1 reqValid = 4'b0;
    pulseCycle = -1;
    res = '0;
    id  = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bcdValid) begin
        pulseCycle = n;
        res = bcdOut;
        id  = bcdId;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int          pc;
  logic [19:0] res;
  logic [1:0]  id;
  int          nRes, nGr;
  int          resCyc [5];
  logic [19:0] resVal [5];
  logic [1:0]  resId  [5];
  int          grId   [5];
  logic [19:0] expTab [4];
  logic        seen;

  initial begin
    rstN      = 1'b0;
    reqValid  = '0;
    reqData   = '0;
    reqValid2 = '0;
    reqData2  = '0;
    expTab[0] = 20'h00100;
    expTab[1] = 20'h02024;
    expTab[2] = 20'h09999;
    expTab[3] = 20'h31337;

    repeat (2) @(negedge clk);
    checkOutput("rst bcd", 32'(bcdOut), 32'h0);
    checkOutput("rst id", 32'(bcdId), 32'h0);
    checkOutput("rst valid", 32'(bcdValid), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst ready", 32'(reqReady), 32'h0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 16'd0, pc, res, id);
    checkOutput("zero cycle", 32'(pc), 32'd17);
    checkOutput("zero bcd", 32'(res), 32'h00000);
    checkOutput("zero id", 32'(id), 32'd0);
    checkOutput("idle busy", 32'(busy), 32'h0);

    applyStimulus(2, 16'd12345, pc, res, id);
    checkOutput("12345 cycle", 32'(pc), 32'd17);
    checkOutput("12345 bcd", 32'(res), 32'h12345);
    checkOutput("12345 id", 32'(id), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold bcd", 32'(bcdOut), 32'h12345);
    checkOutput("hold valid", 32'(bcdValid), 32'h0);

    applyStimulus(2, 16'd65535, pc, res, id);
    checkOutput("65535 bcd", 32'(res), 32'h65535);
    checkOutput("65535 id", 32'(id), 32'd2);

    // Reset during the eighth conversion cycle must discard the result.
    reqValid = 4'b0010;
    reqData[16 +: 16] = 16'd4321;
    @(posedge clk);
    #1 reqValid = 4'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("mid busy", 32'(busy), 32'h1);
    rstN = 1'b0;
    #1;
    checkOutput("abort bcd", 32'(bcdOut), 32'h0);
    checkOutput("abort id", 32'(bcdId), 32'h0);
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort valid", 32'(bcdValid), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      seen = seen | bcdValid;
    end
    checkOutput("abort no pulse", 32'(seen), 32'h0);

    // All four requesters held valid: round robin starting at 0.
    @(posedge clk);
    #1;
    reqValid = 4'hF;
    reqData  = {16'd31337, 16'd9999, 16'd2024, 16'd100};
    nRes = 0;
    nGr  = 0;
    for (int r = 0; r < 5; r++) begin
      resCyc[r] = -1;
      resVal[r] = '0;
      resId[r]  = '0;
      grId[r]   = -1;
    end
    for (int n = 0; n < 120 && nRes < 5; n++) begin
      @(negedge clk);
      if (reqReady != 4'b0 && nGr < 5) begin
        for (int k = 0; k < 4; k++) if (reqReady[k]) grId[nGr] = k;
        nGr++;
      end
      if (bcdValid) begin
        resCyc[nRes] = n;
        resVal[nRes] = bcdOut;
        resId[nRes]  = bcdId;
        nRes++;
      end
    end
    reqValid = 4'b0;
    checkOutput("rr results", 32'(nRes), 32'd5);
    for (int r = 0; r < 5; r++) begin
      checkOutput("rr grant", 32'(grId[r]), 32'(r % 4));
      checkOutput("rr id", 32'(resId[r]), 32'(r % 4));
      checkOutput("rr bcd", 32'(resVal[r]), 32'(expTab[r % 4]));
      if (r > 0) checkOutput("rr spacing", 32'(resCyc[r] - resCyc[r-1]), 32'd18);
    end

    // Requester 3 pulses valid only while requester 0 converts.
    @(posedge clk);
    #1;
    reqValid = 4'b0001;
    reqData[15:0] = 16'd777;
    @(negedge clk);
    checkOutput("pulse test grant", 32'(reqReady), 32'h1);
    @(posedge clk);
    #1 reqValid = 4'b0;
    seen = 1'b0;
    nRes = 0;
    res  = '0;
    id   = '0;
    for (int n = 0; n < 40; n++) begin
      reqValid[3] = (n >= 2 && n <= 12);
      @(negedge clk);
      seen = seen | (|reqReady);
      if (bcdValid) begin
        nRes++;
        res = bcdOut;
        id  = bcdId;
      end
    end
    reqValid = 4'b0;
    checkOutput("convert ready", 32'(seen), 32'h0);
    checkOutput("convert pulses", 32'(nRes), 32'd1);
    checkOutput("convert bcd", 32'(res), 32'h00777);
    checkOutput("convert id", 32'(id), 32'd0);

    // Four-digit instance: 65535 wraps to 5535.
    @(posedge clk);
    #1;
    reqValid2 = 4'b0001;
    reqData2[15:0] = 16'hFFFF;
    @(negedge clk);
    checkOutput("d4 grant", 32'(reqReady2), 32'h1);
    @(posedge clk);
    #1 reqValid2 = 4'b0;
    pc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bcdValid2) begin
        pc = n;
        checkOutput("d4 bcd", 32'(bcdOut2), 32'h5535);
        break;
      end
    end
    checkOutput("d4 cycle", 32'(pc), 32'd17);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bcd_convert_scheduler.md
BCD_CONVERT_SCHEDULER -- requirements
Module: bcd_convert_scheduler

Interface
REQ-001 Parameter INPUT_WIDTH, default 16: bit width of each binary request value.
REQ-002 Parameter DECIMAL_DIGITS, default 5: number of BCD digits produced, 4 bits each.
REQ-003 Parameter NUM_REQ, default 4: number of requesters sharing the converter, minimum 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk_in, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port rst_n_in, input, 1: asynchronous active-low reset.
REQ-007 Port req_valid_in, input, NUM_REQ: bit k high means requester k offers a value.
REQ-008 Port req_data_in, input, NUM_REQ*INPUT_WIDTH: slice [k*INPUT_WIDTH +: INPUT_WIDTH] is requester k's value.
REQ-009 Port req_ready_out, output, NUM_REQ: one-hot grant; a transfer occurs when valid and ready are both high on a rising edge.
REQ-010 Port bcd_out, output, DECIMAL_DIGITS*4: last result, digit 0 (ones) in bits [3:0].
REQ-011 Port bcd_id_out, output, $clog2(NUM_REQ): requester index of bcd_out.
REQ-012 Port bcd_valid_out, output, 1: single-cycle pulse marking a new result.
REQ-013 Port busy_out, output, 1: high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CONVERT and DONE.
REQ-015 IDLE: if any req_valid_in bit is high, req_ready_out SHALL combinationally assert for exactly one requester: the first valid requester strictly after last_grant, searching cyclically.
REQ-016 req_ready_out SHALL be all-zero in CONVERT and DONE and in IDLE when no request is valid.
REQ-017 On transfer, the block SHALL capture the value and index, clear the BCD accumulator, load bit counter = INPUT_WIDTH, update last_grant and enter CONVERT.
REQ-018 Each CONVERT cycle SHALL add 3 to every accumulator digit greater than 4, then shift the accumulator left by one bit, inserting the next binary bit (MSB first), and decrement the counter.
REQ-019 After INPUT_WIDTH CONVERT cycles, the FSM SHALL enter DONE.
REQ-020 DONE SHALL last one cycle: bcd_out and bcd_id_out update and bcd_valid_out is high; the next state is IDLE.
REQ-021 Latency: with a transfer on edge 0, bcd_valid_out SHALL be high during cycle INPUT_WIDTH+1; sustained throughput is one result per INPUT_WIDTH+2 cycles.
REQ-022 bcd_out and bcd_id_out SHALL hold their values until the next DONE.
REQ-023 If 10^DECIMAL_DIGITS is not greater than 2^INPUT_WIDTH-1, bcd_out SHALL equal value mod 10^DECIMAL_DIGITS, with no error flag.
REQ-024 A requester that drops valid before being granted SHALL lose nothing and gain no priority.
REQ-025 Requests arriving during CONVERT or DONE SHALL wait; nothing is queued internally.

Reset
REQ-026 Reset SHALL force state IDLE, bcd_out 0, bcd_id_out 0, bcd_valid_out 0, busy_out 0, counter 0 and last_grant NUM_REQ-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion: no bcd_valid_out pulse, and the result is discarded.

Structure
REQ-028 Package bcd_sched_pkg SHALL hold the state enum and the default parameter constants.
REQ-029 Sub-module bcd_shift_engine SHALL hold the accumulator, shift register and counter, with start/done ports; the arbiter and FSM stay in the top module.

Verification
REQ-030 Reset, then req 0 value 0 -> bcd_out 0x00000, bcd_id_out 0, pulse in cycle 17.
REQ-031 Req 2 value 12345 -> bcd_out 0x12345, bcd_id_out 2; value 65535 -> 0x65535.
REQ-032 All four valid continuously with distinct values -> grants in order 0,1,2,3,0; results spaced 18 cycles apart.
REQ-033 Assert rst_n_in in cycle 8 of a conversion -> no pulse; all outputs 0; the next grant goes to requester 0.
REQ-034 DECIMAL_DIGITS=4, value 65535 -> bcd_out 0x5535.
REQ-035 A request pulsed valid only during CONVERT -> never granted; req_ready_out stays 0 throughout.
